// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch front end.
// Drives the instruction memory with the PC. The memory answers in the same
// cycle, and each returned word is queued with its PC in a small FIFO that
// feeds decode. A backend redirect flushes the queue and reloads the PC.
// Optional feature macro: FETCH_BRANCH_PREDICT_EN (static predict-taken on BR).

`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 5
`endif
`ifndef REG_LEN
`define REG_LEN 8
`endif
`ifndef INST_OP_BR
`define INST_OP_BR 5'b01011
`endif

module inst_fetch #(
  parameter int FQ_DEPTH = 4,
  parameter int ADDR_W   = `MEMI_SIZE_LOG,
  parameter int INST_W   = `INST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] memi_req_addr,
  input  logic [INST_W-1:0] memi_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_pred_taken
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Queue storage is never reset; the valid count alone qualifies its contents.
  logic [ADDR_W-1:0] fq_pc_q   [FQ_DEPTH];
  logic [INST_W-1:0] fq_inst_q [FQ_DEPTH];

  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] next_pc;

  assign memi_req_addr = pc_q;
  assign full          = (count_q == CNT_W'(FQ_DEPTH));
  assign out_valid     = (count_q != '0);
  assign pop           = out_valid & out_ready;
  // A full queue can still accept a word in the same cycle its head leaves.
  assign push          = ~redirect_valid & (~full | pop);

`ifdef FETCH_BRANCH_PREDICT_EN
  localparam int OP_W  = `INST_SIZE_LOG;
  localparam int IMM_W = `REG_LEN;

  logic [OP_W-1:0]  opcode;
  logic [IMM_W-1:0] imm;
  logic             pred;
  logic             fq_pred_q [FQ_DEPTH];

  assign opcode  = memi_resp_data[INST_W-1 -: OP_W];
  assign imm     = memi_resp_data[INST_W-1-OP_W -: IMM_W];
  assign pred    = (opcode == OP_W'(`INST_OP_BR));
  // Predicted-taken target wraps in the address space like the sequential PC.
  assign next_pc = pred ? (pc_q + ADDR_W'(imm)) : (pc_q + ADDR_W'(1));

  assign out_pred_taken = out_valid & fq_pred_q[rd_ptr_q];

  // Record the prediction alongside the queued word.
  always_ff @(posedge clk) begin
    if (push) fq_pred_q[wr_ptr_q] <= pred;
  end
`else
  assign next_pc        = pc_q + ADDR_W'(1);
  assign out_pred_taken = 1'b0;
`endif

  // Head of the queue drives decode; zero while the queue is empty.
  assign out_pc   = out_valid ? fq_pc_q[rd_ptr_q]   : '0;
  assign out_inst = out_valid ? fq_inst_q[rd_ptr_q] : '0;

  // Next PC and queue bookkeeping; a redirect overrides push and pop.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = next_pc;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // PC and queue control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Capture the fetched word and its PC at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc_q[wr_ptr_q]   <= pc_q;
      fq_inst_q[wr_ptr_q] <= memi_resp_data;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table plus hand sequences
// for address wrap, branch prediction and asynchronous reset.

`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 5
`endif
`ifndef REG_LEN
`define REG_LEN 8
`endif
`ifndef INST_OP_BR
`define INST_OP_BR 5'b01011
`endif

module tb_inst_fetch;
  localparam int FQ_DEPTH = 4;
  localparam int ADDR_W   = `MEMI_SIZE_LOG;
  localparam int INST_W   = `INST_LEN;
  localparam int OP_W     = `INST_SIZE_LOG;
  localparam int IMM_W    = `REG_LEN;
  localparam int REST_W   = INST_W - OP_W - IMM_W;
  localparam logic [OP_W-1:0]   OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0]   OP_BR  = OP_W'(`INST_OP_BR);
  localparam logic [ADDR_W-1:0] MAXPC  = {ADDR_W{1'b1}};
`ifdef FETCH_BRANCH_PREDICT_EN
  localparam logic [ADDR_W-1:0] BR_NEXT = ADDR_W'(7);
  localparam logic              BR_PRED = 1'b1;
`else
  localparam logic [ADDR_W-1:0] BR_NEXT = ADDR_W'(3);
  localparam logic              BR_PRED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] memi_req_addr;
  logic [INST_W-1:0] memi_resp_data;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [INST_W-1:0] out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              out_pred_taken;

  logic [INST_W-1:0] mem [2**ADDR_W];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              ready;
    logic              redir;
    logic [ADDR_W-1:0] rpc;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vecs [32];

  inst_fetch #(.FQ_DEPTH(FQ_DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .memi_req_addr  (memi_req_addr),
    .memi_resp_data (memi_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pred_taken (out_pred_taken)
  );

  // Combinational instruction memory.
  assign memi_resp_data = mem[memi_req_addr];

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] add_word(input int i);
    return {OP_ADD, IMM_W'(0), REST_W'(i * 7 + 3)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic ev, input logic [ADDR_W-1:0] epc,
                          input logic [ADDR_W-1:0] eaddr, input logic epred);
    chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".addr"}, 64'(memi_req_addr), 64'(eaddr));
    if (ev) begin
      chk({tag, ".pc"}, 64'(out_pc), 64'(epc));
      chk({tag, ".inst"}, 64'(out_inst), 64'(mem[epc]));
      chk({tag, ".pred"}, 64'(out_pred_taken), 64'(epred));
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [ADDR_W-1:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = add_word(i);

    // Vector table: row k checks the state before applying its inputs.
    for (int k = 0; k < 32; k++) begin
      vecs[k].ready = 1'b1; vecs[k].redir = 1'b0; vecs[k].rpc = '0;
      vecs[k].exp_valid = 1'b1; vecs[k].exp_pc = '0; vecs[k].exp_addr = '0;
    end
    vecs[0].exp_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      vecs[k].exp_pc = ADDR_W'(k - 1); vecs[k].exp_addr = ADDR_W'(k);
    end
    for (int k = 8; k <= 17; k++) vecs[k].ready = 1'b0;
    vecs[9].exp_pc = 7;  vecs[9].exp_addr = 9;
    vecs[10].exp_pc = 7; vecs[10].exp_addr = 10;
    for (int k = 11; k <= 18; k++) begin
      vecs[k].exp_pc = 7; vecs[k].exp_addr = 11;
    end
    for (int k = 19; k <= 23; k++) begin
      vecs[k].exp_pc = ADDR_W'(k - 11); vecs[k].exp_addr = ADDR_W'(k - 7);
    end
    vecs[23].redir = 1'b1; vecs[23].rpc = 5;
    vecs[24].exp_valid = 1'b0; vecs[24].exp_addr = 5;
    vecs[25].exp_pc = 5; vecs[25].exp_addr = 6;
    vecs[26].exp_pc = 6; vecs[26].exp_addr = 7;
    vecs[27].exp_pc = 7; vecs[27].exp_addr = 8;
    vecs[27].redir = 1'b1; vecs[27].rpc = 20;
    vecs[28].exp_valid = 1'b0; vecs[28].exp_addr = 20;
    vecs[28].redir = 1'b1; vecs[28].rpc = 30;
    vecs[29].exp_valid = 1'b0; vecs[29].exp_addr = 30;
    vecs[30].exp_pc = 30; vecs[30].exp_addr = 31;
    vecs[31].exp_pc = 31; vecs[31].exp_addr = 32;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.pc", 64'(out_pc), 64'(0));
    chk("rst.inst", 64'(out_inst), 64'(0));
    chk("rst.pred", 64'(out_pred_taken), 64'(0));
    chk("rst.addr", 64'(memi_req_addr), 64'(0));
    rst = 1'b1;

    for (int k = 0; k < 32; k++) begin
      chk_head($sformatf("row%0d", k), vecs[k].exp_valid, vecs[k].exp_pc,
               vecs[k].exp_addr, 1'b0);
      drive(vecs[k].ready, vecs[k].redir, vecs[k].rpc);
      @(negedge clk);
    end

    // Address wrap at the top of the PC range.
    drive(1'b1, 1'b1, MAXPC - ADDR_W'(1));
    @(negedge clk);
    chk_head("wrap0", 1'b0, '0, MAXPC - ADDR_W'(1), 1'b0);
    drive(1'b1, 1'b0, '0);
    @(negedge clk);
    chk_head("wrap1", 1'b1, MAXPC - ADDR_W'(1), MAXPC, 1'b0);
    @(negedge clk);
    chk_head("wrap2", 1'b1, MAXPC, '0, 1'b0);
    @(negedge clk);
    chk_head("wrap3", 1'b1, '0, ADDR_W'(1), 1'b0);
    chk("wrap.no_x", 64'($isunknown({out_valid, out_pc, out_inst, memi_req_addr})), 64'(0));

    // Branch with imm=5 at address 2.
    mem[2] = {OP_BR, IMM_W'(5), REST_W'(0)};
    drive(1'b1, 1'b1, '0);
    @(negedge clk);
    chk_head("br0", 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0);
    @(negedge clk);
    chk_head("br1", 1'b1, ADDR_W'(0), ADDR_W'(1), 1'b0);
    @(negedge clk);
    chk_head("br2", 1'b1, ADDR_W'(1), ADDR_W'(2), 1'b0);
    @(negedge clk);
    chk_head("br3", 1'b1, ADDR_W'(2), BR_NEXT, BR_PRED);
    @(negedge clk);
    chk_head("br4", 1'b1, BR_NEXT, BR_NEXT + ADDR_W'(1), 1'b0);

    // Asynchronous reset mid-stream.
    @(negedge clk);
    chk("arst.pre_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", 64'(out_valid), 64'(0));
    chk("arst.pc", 64'(out_pc), 64'(0));
    chk("arst.inst", 64'(out_inst), 64'(0));
    chk("arst.addr", 64'(memi_req_addr), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    chk_head("arst0", 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk_head("arst1", 1'b1, ADDR_W'(0), ADDR_W'(1), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
